// File: rtl/data_memory_target_if.sv
// -----------------------------------------------------------------------------
// data_memory_target_if
// Purpose : groups the initiator-side control signals of the data memory
//           target (address, strobes, status) into one bundle.
// Signals : bus_addr  - access address from the initiator
//           mem_cs    - chip select
//           mem_we    - write enable
//           mem_oe    - output enable (read)
//           err_clr   - synchronous clear of the sticky error flag
//           busy      - target is running its post-reset clear sequence
//           err       - sticky access-error flag
// Modports: master (initiator side), slave (memory target side).
// The bidirectional data bus stays a plain inout port on the target so the
// tri-state resolution happens on an ordinary net.
// -----------------------------------------------------------------------------
interface data_memory_target_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic                  err_clr;
    logic                  busy;
    logic                  err;

    modport master (
        output bus_addr, mem_cs, mem_we, mem_oe, err_clr,
        input  busy, err
    );

    modport slave (
        input  bus_addr, mem_cs, mem_we, mem_oe, err_clr,
        output busy, err
    );
endinterface

// File: rtl/data_memory_target.sv
// -----------------------------------------------------------------------------
// data_memory_target
// Purpose : memory-mapped data RAM target with a zero-latency read on a shared
//           tri-state data bus. After reset the array is cleared one word per
//           cycle (busy high); accesses during that time, accesses outside the
//           decoded window and simultaneous write+read strobes set a sticky
//           error flag.
// Ports   : clk      - single clock, rising edge
//           reset    - asynchronous, active-low reset
//           bus      - data_memory_target_if.slave (addr, cs, we, oe,
//                      err_clr in; busy, err out)
//           bus_data - inout data bus, driven only during a valid read
// Option  : define DATA_MEM_PARITY_EN to store an even-parity bit per word
//           and flag a parity mismatch on read through err.
// -----------------------------------------------------------------------------
module data_memory_target #(
    parameter int          DATA_WIDTH     = 8,
    parameter int          ADDR_WIDTH     = 16,
    parameter int unsigned MEM_START_ADDR = 32'h0000_0040,
    parameter int unsigned MEM_STOP_ADDR  = 32'h0000_00BF
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_target_if.slave     bus,
    inout  wire  [DATA_WIDTH-1:0]   bus_data
);
    localparam int DEPTH = int'(MEM_STOP_ADDR - MEM_START_ADDR) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(MEM_START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STOP_A  = ADDR_WIDTH'(MEM_STOP_ADDR);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef DATA_MEM_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [IDX_W-1:0]  clr_ptr_r;
    logic [IDX_W-1:0]  clr_ptr_nxt_s;
    logic              err_r;
    logic              err_nxt_s;

    logic [WORD_W-1:0] mem_r [DEPTH];

    logic              busy_s;
    logic              in_range_s;
    logic              hit_s;
    logic              access_s;
    logic              rd_en_s;
    logic              wr_en_s;
    logic              err_set_s;
    logic              par_err_s;
    logic [IDX_W-1:0]  idx_s;
    logic [WORD_W-1:0] rd_word_s;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic parity_even(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

    assign busy_s     = (state_r == CLEAR);
    assign in_range_s = (bus.bus_addr >= START_A) && (bus.bus_addr <= STOP_A);
    assign hit_s      = bus.mem_cs && in_range_s;
    assign access_s   = bus.mem_cs && (bus.mem_we || bus.mem_oe);
    assign idx_s      = IDX_W'(bus.bus_addr - START_A);
    assign rd_word_s  = mem_r[idx_s];

    // A read drives only when it is unambiguous: no write strobe, not busy.
    assign rd_en_s = hit_s && bus.mem_oe && !bus.mem_we && !busy_s;
    // A write with both strobes still lands; only the busy phase blocks it.
    assign wr_en_s = hit_s && bus.mem_we && !busy_s;

    assign bus_data = rd_en_s ? rd_word_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'bz}};

`ifdef DATA_MEM_PARITY_EN
    assign par_err_s = rd_en_s &&
                       (rd_word_s[DATA_WIDTH] != parity_even(rd_word_s[DATA_WIDTH-1:0]));
`else
    assign par_err_s = 1'b0;
`endif

    assign err_set_s = (access_s && busy_s)
                     || (access_s && !in_range_s)
                     || (bus.mem_cs && bus.mem_we && bus.mem_oe)
                     || par_err_s;

    assign bus.busy = busy_s;
    assign bus.err  = err_r;

    // Next-state, clear pointer and sticky error update.
    always_comb begin
        next_state_s  = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        err_nxt_s     = err_r;
        case (state_r)
            CLEAR: begin
                clr_ptr_nxt_s = clr_ptr_r + IDX_W'(1);
                if (clr_ptr_r == LAST_IDX) begin
                    next_state_s = READY;
                end else begin
                    next_state_s = CLEAR;
                end
            end
            READY: begin
                next_state_s = READY;
            end
            default: begin
                next_state_s  = CLEAR;
                clr_ptr_nxt_s = '0;
            end
        endcase
        // A fresh error outranks a clear request in the same cycle.
        if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else if (bus.err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // State, clear pointer and error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= CLEAR;
            clr_ptr_r <= '0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            clr_ptr_r <= clr_ptr_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    // Storage array: zero-fill while clearing, otherwise accept bus writes.
    // No reset here; the clear sequence initialises every word.
    always_ff @(posedge clk) begin
        if (busy_s) begin
            mem_r[clr_ptr_r] <= '0;
        end else if (wr_en_s) begin
`ifdef DATA_MEM_PARITY_EN
            mem_r[idx_s] <= {parity_even(bus_data), bus_data};
`else
            mem_r[idx_s] <= bus_data;
`endif
        end
    end
endmodule
